instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction-fetch stage of the pipeline: owns the program counter, drives the instruction ROM address, and registers the returned 16-bit microcode into the IF/ID pipeline register that feeds the decoder. It applies downstream stalls, redirects the PC on a taken branch with a one-bubble flush, and inserts bubbles after reset. Sits directly upstream of the decoder; the decoder consumes `oInstruction` unmodified.

## Interface
- `ADDR_WIDTH`, 10: PC / ROM address width.
- `RESET_VECTOR`, 0: PC value loaded on reset.
- `NOP_WORD`, 16'hFC00: bubble microcode; opcode 6'h3F, decoded as the all-zero-controls default.

- `Clock`  in  1  single clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `iStall`  in  1  hold PC and IF/ID contents this cycle.
- `iBranchTaken`  in  1  redirect PC to `iBranchTarget`, flush IF/ID.
- `iBranchTarget`  in  ADDR_WIDTH  branch destination.
- `iRomData`  in  16  ROM read data for `oRomAddress` (combinational ROM).
- `oRomAddress`  out  ADDR_WIDTH  current PC.
- `oInstruction`  out  16  IF/ID register to the decoder.
- `oInstructionPC`  out  ADDR_WIDTH  PC of the instruction in `oInstruction`.
- `oValid`  out  1  high when `oInstruction` is a real fetched instruction, low on bubble.
- `oHalted`  out  1  fetch halted (only meaningful with `FETCH_HALT_EN`; otherwise tied 0).

## Operation
- State machine, 3 states: `S_BOOT`, `S_RUN`, `S_HALT`.
- `S_BOOT`: entered on `Reset`. PC = `RESET_VECTOR`, IF/ID = `NOP_WORD`, `oValid`=0. Next cycle unconditionally `S_RUN`, one bubble emitted.
- `S_RUN`, per cycle, priority high to low:
  - `iBranchTaken`: PC ← `iBranchTarget`; IF/ID ← `NOP_WORD`, `oValid` ← 0 (squash wrong-path fetch). Overrides `iStall`.
  - `iStall`: PC, `oInstruction`, `oInstructionPC`, `oValid` hold.
  - else: IF/ID ← `iRomData`, `oInstructionPC` ← PC, `oValid` ← 1; PC ← PC + 1.
- PC increment modulo 2^ADDR_WIDTH: all-ones wraps to 0, no flag.
- `iBranchTarget` used at full width, no offset arithmetic.
- `S_HALT`: see Configuration; exits only via `Reset`.

## Timing
- Reset values: `oRomAddress`=`RESET_VECTOR`, `oInstruction`=`NOP_WORD`, `oInstructionPC`=0, `oValid`=0, `oHalted`=0.
- ROM read is combinational within the cycle; instruction at address N appears on `oInstruction` one edge after PC=N is presented, unstalled.
- First valid instruction (`RESET_VECTOR`) on `oInstruction` 2 edges after `Reset` deasserts (boot bubble + fetch).
- Taken branch: target instruction on `oInstruction` 2 edges after `iBranchTaken` sampled; exactly one bubble between.
- Stall asserted k cycles: outputs frozen k cycles, no instruction lost or duplicated.
- `Reset` mid-operation (including during stall, branch, halt): synchronous, overrides all inputs, returns to `S_BOOT`.
- Branch and stall same cycle: branch taken, stall ignored.

## Configuration
- `FETCH_HALT_EN` defined: when an unstalled fetch in `S_RUN` loads an instruction with opcode `iRomData[15:10]` == 6'h3E, that instruction is latched valid, PC does not advance, state → `S_HALT`. In `S_HALT`: PC frozen, IF/ID ← `NOP_WORD`, `oValid`=0, `oHalted`=1; `iBranchTaken` and `iStall` ignored.
- Undefined: no `S_HALT` state; opcode 6'h3E fetched as ordinary instruction; `oHalted` constant 0.

## Test plan
- Reset release, ROM[a]=16'h0400+a: bubble on first edge, then `oInstruction`=16'h0400, 16'h0401, 16'h0402 with `oInstructionPC`=0,1,2, `oValid`=1.
- `iStall` high 3 cycles while `oInstructionPC`=5: outputs hold PC 5 for 3 cycles, next edge shows PC 6; no skip.
- `iBranchTaken`=1, `iBranchTarget`=10'h120 while PC=7: next edge `oInstruction`=16'hFC00, `oValid`=0, then instruction at 0x120 with `oInstructionPC`=0x120.
- Branch and stall same cycle, target 10'h040: branch honoured; instruction at 0x040 appears 2 edges later.
- PC at 10'h3FF unstalled: next fetch address 0, `oInstructionPC` sequence 0x3FF, 0x000.
- `FETCH_HALT_EN`, ROM[3]=16'hF800: instruction at 3 emitted valid, then `oHalted`=1, `oValid`=0, PC stays 3 despite branch; `Reset` restarts from 0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: pipeline control inputs, ROM port and IF/ID outputs.
// The fetch stage connects through the master modport; the surrounding
// pipeline (stall/branch logic, ROM, decoder) uses the slave modport.
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  iStall;
  logic                  iBranchTaken;
  logic [ADDR_WIDTH-1:0] iBranchTarget;
  logic [15:0]           iRomData;
  logic [ADDR_WIDTH-1:0] oRomAddress;
  logic [15:0]           oInstruction;
  logic [ADDR_WIDTH-1:0] oInstructionPC;
  logic                  oValid;
  logic                  oHalted;

  modport master (
    input  iStall, iBranchTaken, iBranchTarget, iRomData,
    output oRomAddress, oInstruction, oInstructionPC, oValid, oHalted
  );

  modport slave (
    output iStall, iBranchTaken, iBranchTarget, iRomData,
    input  oRomAddress, oInstruction, oInstructionPC, oValid, oHalted
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction ROM and registers the returned microcode into IF/ID.
// Handles downstream stalls, taken-branch redirect with a one-bubble
// flush and a boot bubble after reset.
// Optional feature: define FETCH_HALT_EN to enable the S_HALT state,
// entered when opcode 6'h3E is fetched; otherwise oHalted is tied 0.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH   = 10,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [15:0]           NOP_WORD     = 16'hFC00
) (
  input  logic                 Clock,
  input  logic                 Reset,
  instruction_fetch_if.master  bus
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
`ifdef FETCH_HALT_EN
  localparam logic [1:0] S_HALT      = 2'd2;
  localparam logic [5:0] HALT_OPCODE = 6'h3E;
`endif

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = 1;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  valid_q, valid_d;

  // Next-state logic: boot bubble, then branch > stall > sequential fetch.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;

    case (state_q)
      S_BOOT: begin
        // One bubble before the first fetch; PC stays on the vector.
        state_d = S_RUN;
        pc_d    = RESET_VECTOR;
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end

      S_RUN: begin
        if (bus.iBranchTaken) begin
          // Redirect and squash the wrong-path word; stall is ignored.
          pc_d    = bus.iBranchTarget;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (!bus.iStall) begin
          instr_d    = bus.iRomData;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + PC_ONE;  // wraps modulo 2^ADDR_WIDTH
`ifdef FETCH_HALT_EN
          if (bus.iRomData[15:10] == HALT_OPCODE) begin
            // Halt word is delivered valid, but the PC stops on it.
            pc_d    = pc_q;
            state_d = S_HALT;
          end
`endif
        end
      end

`ifdef FETCH_HALT_EN
      S_HALT: begin
        // Frozen until reset; branch and stall have no effect here.
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
`endif

      default: begin
        // Unreachable encodings recover through the boot sequence.
        state_d = S_BOOT;
        pc_d    = RESET_VECTOR;
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and IF/ID register update with synchronous active-high reset.
  always_ff @(posedge Clock) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    if (Reset) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VECTOR;
      instr_q    <= NOP_WORD;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.oRomAddress    = pc_q;
  assign bus.oInstruction   = instr_q;
  assign bus.oInstructionPC = instr_pc_q;
  assign bus.oValid         = valid_q;
`ifdef FETCH_HALT_EN
  assign bus.oHalted        = (state_q == S_HALT);
`else
  assign bus.oHalted        = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios with
// literal expectations, then randomized stall/branch/reset traffic, all
// compared every cycle against a behavioural model of the fetch stage.
module tb_instruction_fetch;

  localparam int          AW    = 10;
  localparam int          DEPTH = 1 << AW;
  localparam logic [15:0] NOP   = 16'hFC00;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          stall;
  logic          br;
  logic [AW-1:0] tgt;
  logic [15:0]   rom [DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  instruction_fetch_if #(.ADDR_WIDTH(AW)) bus ();

  instruction_fetch #(
    .ADDR_WIDTH  (AW),
    .RESET_VECTOR('0),
    .NOP_WORD    (NOP)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus)
  );

  assign bus.iStall        = stall;
  assign bus.iBranchTaken  = br;
  assign bus.iBranchTarget = tgt;
  assign bus.iRomData      = rom[bus.oRomAddress];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: what the stage must present after each edge.
  bit          m_known = 1'b0;
  bit          m_boot;
  bit          m_halt;
  int          m_pc;
  logic [15:0] m_ins;
  int          m_ipc;
  bit          m_v;

  always @(posedge clk) begin
    if (rst) begin
      m_known <= 1'b1;
      m_boot  <= 1'b1;
      m_halt  <= 1'b0;
      m_pc    <= 0;
      m_ins   <= NOP;
      m_ipc   <= 0;
      m_v     <= 1'b0;
    end else if (m_known) begin
      if (m_boot) begin
        m_boot <= 1'b0;
        m_ins  <= NOP;
        m_v    <= 1'b0;
      end else if (m_halt) begin
        m_ins <= NOP;
        m_v   <= 1'b0;
      end else if (br) begin
        m_pc  <= int'(tgt);
        m_ins <= NOP;
        m_v   <= 1'b0;
      end else if (!stall) begin
        m_ins <= rom[m_pc];
        m_ipc <= m_pc;
        m_v   <= 1'b1;
        if (HALT_EN && rom[m_pc][15:10] == 6'h3E) m_halt <= 1'b1;
        else m_pc <= (m_pc + 1) % DEPTH;
      end
    end
  end

  // Every-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    if (m_known) begin
      check("rom_addr", 32'(bus.oRomAddress),    32'(m_pc));
      check("instr",    32'(bus.oInstruction),   32'(m_ins));
      check("instr_pc", 32'(bus.oInstructionPC), 32'(m_ipc));
      check("valid",    32'(bus.oValid),         32'(m_v));
      check("halted",   32'(bus.oHalted),        32'(m_halt));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic [15:0] ins,
                            input int ipc, input bit v);
    check({name, "_instr"}, 32'(bus.oInstruction), 32'(ins));
    check({name, "_pc"},    32'(bus.oInstructionPC), 32'(ipc));
    check({name, "_valid"}, 32'(bus.oValid), 32'(v));
  endtask

  task automatic init_rom();
    for (int a = 0; a < DEPTH; a++) rom[a] = 16'h0400 + 16'(a);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = '0;
    init_rom();
    tick();
    tick();

    // Reset values.
    expect_out("reset", NOP, 0, 1'b0);
    check("reset_addr",   32'(bus.oRomAddress), 32'h0);
    check("reset_halted", 32'(bus.oHalted),     32'h0);

    // Boot bubble, then sequential fetch from the reset vector.
    rst = 1'b0;
    tick(); expect_out("boot", NOP, 0, 1'b0);
    tick(); expect_out("seq0", 16'h0400, 0, 1'b1);
    tick(); expect_out("seq1", 16'h0401, 1, 1'b1);
    tick(); expect_out("seq2", 16'h0402, 2, 1'b1);
    tick(); tick(); tick();
    expect_out("pre_stall", 16'h0405, 5, 1'b1);

    // Three-cycle stall holds PC 5, then PC 6 with nothing skipped.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); expect_out("stall", 16'h0405, 5, 1'b1);
    end
    stall = 1'b0;
    tick(); expect_out("post_stall", 16'h0406, 6, 1'b1);
    check("post_stall_addr", 32'(bus.oRomAddress), 32'h7);

    // Taken branch from PC 7 to 0x120: one bubble, then the target.
    br = 1'b1; tgt = 10'h120;
    tick(); expect_out("br_bubble", NOP, 6, 1'b0);
    check("br_addr", 32'(bus.oRomAddress), 32'h120);
    br = 1'b0;
    tick(); expect_out("br_target", 16'h0520, 10'h120, 1'b1);

    // Branch and stall together: branch wins.
    br = 1'b1; stall = 1'b1; tgt = 10'h040;
    tick(); check("brst_valid", 32'(bus.oValid), 32'h0);
    br = 1'b0; stall = 1'b0;
    tick(); expect_out("brst_target", 16'h0440, 10'h040, 1'b1);

    // PC wrap from 0x3FF to 0.
    br = 1'b1; tgt = 10'h3FE;
    tick();
    br = 1'b0;
    tick(); expect_out("wrap_3fe", 16'h07FE, 10'h3FE, 1'b1);
    tick(); expect_out("wrap_3ff", 16'h07FF, 10'h3FF, 1'b1);
    tick(); expect_out("wrap_000", 16'h0400, 0, 1'b1);
    check("wrap_addr", 32'(bus.oRomAddress), 32'h1);

`ifdef FETCH_HALT_EN
    // Halt on opcode 6'h3E at address 3, ignore branch, restart on reset.
    rst = 1'b1; rom[3] = 16'hF800;
    tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    tick(); expect_out("halt_word", 16'hF800, 3, 1'b1);
    check("halt_word_addr", 32'(bus.oRomAddress), 32'h3);
    tick(); check("halted", 32'(bus.oHalted), 32'h1);
    check("halted_valid", 32'(bus.oValid), 32'h0);
    br = 1'b1; tgt = 10'h100;
    tick(); check("halt_ignores_br", 32'(bus.oRomAddress), 32'h3);
    br = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick(); expect_out("restart", 16'h0400, 0, 1'b1);
    rom[3] = 16'h0403;
`endif

    // Randomized traffic against the model.
    for (int a = 0; a < DEPTH; a++) begin
      rom[a] = 16'($urandom);
      if (rom[a][15:10] == 6'h3E && $urandom_range(0, 3) != 0) rom[a][10] = 1'b1;
    end
    for (int c = 0; c < 4000; c++) begin
      stall = ($urandom_range(0, 9) < 3);
      br    = ($urandom_range(0, 9) == 0);
      tgt   = AW'($urandom_range(0, DEPTH - 1));
      rst   = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; stall = 1'b0; br = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
